// File: rtl/pc_gen_unit_if.sv
// Fetch-side bundle for pc_gen_unit: redirect channels, stall/RVC hints and
// the icache request handshake. The master modport is the PC generator.
interface pc_gen_unit_if #(
  parameter int XLEN      = 64,
  parameter int NUM_REDIR = 4,
  parameter int EPOCH_W   = 2
);
  logic [NUM_REDIR-1:0]      redir_valid_i;
  logic [NUM_REDIR*XLEN-1:0] redir_pc_i;
  logic                      stall_i;
  logic                      rvc_step_i;
  logic                      req_valid_o;
  logic                      req_ready_i;
  logic [XLEN-1:0]           req_pc_o;
  logic [EPOCH_W-1:0]        req_epoch_o;
  logic [XLEN-1:0]           pc_o;
  logic                      redir_pending_o;

  modport master (
    input  redir_valid_i, redir_pc_i, stall_i, rvc_step_i, req_ready_i,
    output req_valid_o, req_pc_o, req_epoch_o, pc_o, redir_pending_o
  );

  modport slave (
    output redir_valid_i, redir_pc_i, stall_i, rvc_step_i, req_ready_i,
    input  req_valid_o, req_pc_o, req_epoch_o, pc_o, redir_pending_o
  );
endinterface

// File: rtl/pc_gen_unit.sv
// Fetch PC generator with prioritised redirects and epoch tagging.
// Define PCGEN_RVC_EN to enable 16-bit (+2) stepping and 2-byte target alignment.
module pc_gen_unit #(
  parameter int              XLEN       = 64,
  parameter int              NUM_REDIR  = 4,
  parameter logic [XLEN-1:0] RESET_ADDR = 64'h8000_0000,
  parameter int              EPOCH_W    = 2
) (
  input logic            clk,
  input logic            rst,
  pc_gen_unit_if.master  bus
);

  typedef enum logic [1:0] {IDLE, RUN, PEND} state_e;

  state_e             state_q, state_d;
  logic [XLEN-1:0]    fpc_q, fpc_d;
  logic [XLEN-1:0]    pc_q, pc_d;
  logic [XLEN-1:0]    pend_pc_q, pend_pc_d;
  logic [EPOCH_W-1:0] epoch_q, epoch_d;
  logic [EPOCH_W-1:0] held_epoch_q, held_epoch_d;
  logic               outstanding_q, outstanding_d;

  logic               req_valid;
  logic               handshake;
  logic [EPOCH_W-1:0] req_epoch;
  logic               redir_any;
  logic [XLEN-1:0]    redir_raw;
  logic [XLEN-1:0]    redir_tgt;
  logic [XLEN-1:0]    step;

`ifdef PCGEN_RVC_EN
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(1);
  assign step = bus.rvc_step_i ? XLEN'(2) : XLEN'(4);
`else
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);
  logic unused_rvc;
  assign unused_rvc = bus.rvc_step_i;
  assign step = XLEN'(4);
`endif

  // Scan from the top so the lowest-numbered valid channel wins.
  always_comb begin
    redir_any = 1'b0;
    redir_raw = '0;
    for (int k = NUM_REDIR - 1; k >= 0; k--) begin
      if (bus.redir_valid_i[k]) begin
        redir_any = 1'b1;
        redir_raw = bus.redir_pc_i[k*XLEN +: XLEN];
      end
    end
  end

  assign redir_tgt = redir_raw & ALIGN_MASK;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = RUN;
      RUN:     if (redir_any && req_valid && !handshake) state_d = PEND;
      PEND:    if (handshake) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  // An asserted request is held until accepted and keeps the epoch it was issued with.
  always_comb begin
    req_valid = 1'b0;
    case (state_q)
      RUN:     req_valid = !bus.stall_i || outstanding_q;
      PEND:    req_valid = 1'b1;
      default: req_valid = 1'b0;
    endcase
    handshake = req_valid && bus.req_ready_i;
    req_epoch = outstanding_q ? held_epoch_q : epoch_q;
  end

  always_comb begin
    fpc_d         = fpc_q;
    pc_d          = pc_q;
    pend_pc_d     = pend_pc_q;
    epoch_d       = epoch_q;
    held_epoch_d  = req_epoch;
    outstanding_d = req_valid && !bus.req_ready_i;
    if (redir_any && state_q != IDLE) epoch_d = epoch_q + EPOCH_W'(1);
    case (state_q)
      RUN: begin
        if (handshake) begin
          pc_d  = fpc_q;
          fpc_d = redir_any ? redir_tgt : fpc_q + step;
        end else if (redir_any) begin
          if (req_valid) pend_pc_d = redir_tgt;
          else           fpc_d     = redir_tgt;
        end
      end
      PEND: begin
        if (redir_any) pend_pc_d = redir_tgt;
        if (handshake) begin
          pc_d  = fpc_q;
          fpc_d = redir_any ? redir_tgt : pend_pc_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fpc_q         <= RESET_ADDR;
      pc_q          <= RESET_ADDR;
      pend_pc_q     <= '0;
      epoch_q       <= '0;
      held_epoch_q  <= '0;
      outstanding_q <= 1'b0;
    end else begin
      fpc_q         <= fpc_d;
      pc_q          <= pc_d;
      pend_pc_q     <= pend_pc_d;
      epoch_q       <= epoch_d;
      held_epoch_q  <= held_epoch_d;
      outstanding_q <= outstanding_d;
    end
  end

  assign bus.req_valid_o     = req_valid;
  assign bus.req_pc_o        = fpc_q;
  assign bus.req_epoch_o     = req_epoch;
  assign bus.pc_o            = pc_q;
  assign bus.redir_pending_o = (state_q == PEND);

endmodule

// File: tb/tb_pc_gen_unit.sv
// Directed vector bench for pc_gen_unit: one table plus hand-written
// sequences for pending redirects, epoch wrap, mid-flight reset and RVC stepping.
module tb_pc_gen_unit;

  localparam logic [63:0] B = 64'h8000_0000;
  localparam logic [63:0] Z = 64'h0;
`ifdef PCGEN_RVC_EN
  localparam logic [63:0] RVC_NEXT = 64'h8000_0002;
  localparam logic [63:0] T103     = 64'h102;
  localparam logic [63:0] T1F3     = 64'h1F2;
`else
  localparam logic [63:0] RVC_NEXT = 64'h8000_0004;
  localparam logic [63:0] T103     = 64'h100;
  localparam logic [63:0] T1F3     = 64'h1F0;
`endif

  typedef struct {
    bit              chk;
    bit              rst;
    bit              stall;
    bit              rvc;
    bit              ready;
    logic [3:0]      rdv;
    logic [3:0][63:0] tgt;
    bit              e_valid;
    logic [63:0]     e_req;
    logic [1:0]      e_ep;
    logic [63:0]     e_pc;
    bit              e_pend;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   num_compared   = 0;
  int   num_mismatched = 0;

  pc_gen_unit_if #(.XLEN(64), .NUM_REDIR(4), .EPOCH_W(2)) bus ();

  pc_gen_unit #(
    .XLEN(64), .NUM_REDIR(4), .RESET_ADDR(64'h8000_0000), .EPOCH_W(2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(bit chk, bit r, bit stall, bit rvc, bit ready, logic [3:0] rdv,
                              logic [63:0] t0, logic [63:0] t1, logic [63:0] t2, logic [63:0] t3,
                              bit ev, logic [63:0] ereq, logic [1:0] eep, logic [63:0] epc, bit epend);
    vec_t v;
    v.chk = chk; v.rst = r; v.stall = stall; v.rvc = rvc; v.ready = ready; v.rdv = rdv;
    v.tgt[0] = t0; v.tgt[1] = t1; v.tgt[2] = t2; v.tgt[3] = t3;
    v.e_valid = ev; v.e_req = ereq; v.e_ep = eep; v.e_pc = epc; v.e_pend = epend;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    rst               = v.rst;
    bus.stall_i       = v.stall;
    bus.rvc_step_i    = v.rvc;
    bus.req_ready_i   = v.ready;
    bus.redir_valid_i = v.rdv;
    bus.redir_pc_i    = v.tgt;
  endtask

  task automatic cmp(input string tag, input int idx, input string what,
                     input logic [63:0] got, input logic [63:0] exp);
    num_compared++;
    if (got !== exp) begin
      num_mismatched++;
      $display("[TB] FAIL %s[%0d] %s: got %h expected %h", tag, idx, what, got, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input int idx, input vec_t v);
    cmp(tag, idx, "req_valid", 64'(bus.req_valid_o), 64'(v.e_valid));
    cmp(tag, idx, "req_pc", bus.req_pc_o, v.e_req);
    cmp(tag, idx, "req_epoch", 64'(bus.req_epoch_o), 64'(v.e_ep));
    cmp(tag, idx, "pc", bus.pc_o, v.e_pc);
    cmp(tag, idx, "redir_pending", 64'(bus.redir_pending_o), 64'(v.e_pend));
  endtask

  task automatic runCycle(input string tag, input int idx, input vec_t v);
    @(negedge clk);
    applyStimulus(v);
    #1;
    if (v.chk) checkOutput(tag, idx, v);
  endtask

  vec_t vecs[20];

  initial begin
    applyStimulus(mk(0, 1, 0, 0, 0, 4'b0, Z, Z, Z, Z, 0, Z, 0, Z, 0));

    //              chk rst stl rvc rdy rdv      t0        t1       t2       t3       ev  req        ep pc         pend
    vecs[0]  = mk(0,  1,  0,  0,  1,  4'b0000, Z,        Z,       Z,       Z,       0,  Z,         0, Z,         0);
    vecs[1]  = mk(1,  1,  0,  0,  1,  4'b0000, Z,        Z,       Z,       Z,       0,  B,         0, B,         0);
    vecs[2]  = mk(1,  1,  0,  0,  1,  4'b0000, Z,        Z,       Z,       Z,       0,  B,         0, B,         0);
    vecs[3]  = mk(1,  0,  0,  0,  1,  4'b0000, Z,        Z,       Z,       Z,       0,  B,         0, B,         0);
    vecs[4]  = mk(1,  0,  0,  0,  1,  4'b0000, Z,        Z,       Z,       Z,       1,  B,         0, B,         0);
    vecs[5]  = mk(1,  0,  0,  0,  1,  4'b0000, Z,        Z,       Z,       Z,       1,  B + 4,     0, B,         0);
    vecs[6]  = mk(1,  0,  0,  0,  1,  4'b0000, Z,        Z,       Z,       Z,       1,  B + 8,     0, B + 4,     0);
    vecs[7]  = mk(1,  0,  0,  0,  1,  4'b0110, 64'h777,  64'h100, 64'h200, 64'h999, 1,  B + 12,    0, B + 8,     0);
    vecs[8]  = mk(1,  0,  0,  0,  1,  4'b0000, Z,        Z,       Z,       Z,       1,  64'h100,   1, B + 12,    0);
    vecs[9]  = mk(1,  0,  1,  0,  1,  4'b0000, Z,        Z,       Z,       Z,       0,  64'h104,   1, 64'h100,   0);
    vecs[10] = mk(1,  0,  1,  0,  1,  4'b0001, 64'h1F3,  Z,       Z,       Z,       0,  64'h104,   1, 64'h100,   0);
    vecs[11] = mk(1,  0,  1,  0,  1,  4'b0000, Z,        Z,       Z,       Z,       0,  T1F3,      2, 64'h100,   0);
    vecs[12] = mk(1,  0,  0,  0,  0,  4'b0000, Z,        Z,       Z,       Z,       1,  T1F3,      2, 64'h100,   0);
    vecs[13] = mk(1,  0,  1,  0,  0,  4'b0000, Z,        Z,       Z,       Z,       1,  T1F3,      2, 64'h100,   0);
    vecs[14] = mk(1,  0,  0,  0,  0,  4'b1000, Z,        Z,       Z,       64'h300, 1,  T1F3,      2, 64'h100,   0);
    vecs[15] = mk(1,  0,  0,  0,  0,  4'b0010, Z,        64'h400, Z,       Z,       1,  T1F3,      2, 64'h100,   1);
    vecs[16] = mk(1,  0,  0,  0,  1,  4'b0000, Z,        Z,       Z,       Z,       1,  T1F3,      2, 64'h100,   1);
    vecs[17] = mk(1,  0,  0,  0,  1,  4'b0000, Z,        Z,       Z,       Z,       1,  64'h400,   0, T1F3,      0);
    vecs[18] = mk(1,  1,  0,  0,  0,  4'b0000, Z,        Z,       Z,       Z,       1,  64'h404,   0, 64'h400,   0);
    vecs[19] = mk(1,  0,  0,  0,  1,  4'b0000, Z,        Z,       Z,       Z,       0,  B,         0, B,         0);

    for (int i = 0; i < 20; i++) runCycle("table", i, vecs[i]);

    // Pending redirect at 0x8000_0004, double redirect, epoch wrap, then reset while pending.
    runCycle("pend", 0,  mk(0, 1, 0, 0, 1, 4'b0000, Z, Z, Z, Z, 0, Z, 0, Z, 0));
    runCycle("pend", 1,  mk(1, 0, 0, 0, 1, 4'b0000, Z, Z, Z, Z, 0, B, 0, B, 0));
    runCycle("pend", 2,  mk(1, 0, 0, 0, 1, 4'b0000, Z, Z, Z, Z, 1, B, 0, B, 0));
    runCycle("pend", 3,  mk(1, 0, 0, 0, 0, 4'b0000, Z, Z, Z, Z, 1, B + 4, 0, B, 0));
    runCycle("pend", 4,  mk(1, 0, 0, 0, 0, 4'b1000, Z, Z, Z, 64'h300, 1, B + 4, 0, B, 0));
    runCycle("pend", 5,  mk(1, 0, 1, 0, 0, 4'b0000, Z, Z, Z, Z, 1, B + 4, 0, B, 1));
    runCycle("pend", 6,  mk(1, 0, 0, 0, 0, 4'b0001, 64'h400, Z, Z, Z, 1, B + 4, 0, B, 1));
    runCycle("pend", 7,  mk(1, 0, 0, 0, 1, 4'b0000, Z, Z, Z, Z, 1, B + 4, 0, B, 1));
    runCycle("pend", 8,  mk(1, 0, 0, 0, 1, 4'b0000, Z, Z, Z, Z, 1, 64'h400, 2, B + 4, 0));
    runCycle("pend", 9,  mk(1, 0, 0, 0, 1, 4'b0001, 64'h500, Z, Z, Z, 1, 64'h404, 2, 64'h400, 0));
    runCycle("pend", 10, mk(1, 0, 0, 0, 1, 4'b0001, 64'h600, Z, Z, Z, 1, 64'h500, 3, 64'h404, 0));
    runCycle("pend", 11, mk(1, 0, 0, 0, 1, 4'b0000, Z, Z, Z, Z, 1, 64'h600, 0, 64'h500, 0));
    runCycle("pend", 12, mk(1, 0, 0, 0, 0, 4'b0000, Z, Z, Z, Z, 1, 64'h604, 0, 64'h600, 0));
    runCycle("pend", 13, mk(1, 0, 0, 0, 0, 4'b0100, Z, Z, 64'h700, Z, 1, 64'h604, 0, 64'h600, 0));
    runCycle("pend", 14, mk(1, 1, 0, 0, 0, 4'b0000, Z, Z, Z, Z, 1, 64'h604, 0, 64'h600, 1));
    runCycle("pend", 15, mk(1, 0, 0, 0, 1, 4'b0000, Z, Z, Z, Z, 0, B, 0, B, 0));
    runCycle("pend", 16, mk(1, 0, 0, 0, 1, 4'b0000, Z, Z, Z, Z, 1, B, 0, B, 0));

    // Compressed step and redirect target alignment.
    runCycle("rvc", 0, mk(0, 1, 0, 0, 1, 4'b0000, Z, Z, Z, Z, 0, Z, 0, Z, 0));
    runCycle("rvc", 1, mk(1, 0, 0, 0, 1, 4'b0000, Z, Z, Z, Z, 0, B, 0, B, 0));
    runCycle("rvc", 2, mk(1, 0, 0, 1, 1, 4'b0000, Z, Z, Z, Z, 1, B, 0, B, 0));
    runCycle("rvc", 3, mk(1, 0, 1, 0, 1, 4'b0010, Z, 64'h103, Z, Z, 0, RVC_NEXT, 0, B, 0));
    runCycle("rvc", 4, mk(1, 0, 1, 0, 1, 4'b0000, Z, Z, Z, Z, 0, T103, 1, B, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched);
    $finish;
  end

endmodule
